adder_arbiter: RTL and testbench
================================

# adder_arbiter

Shares one registered 8-bit adder among `NUM_REQ` requesters. Each requester presents two operands with a valid/ready handshake. The block arbitrates between them, sequences the operation through the adder, and returns the sum with the winner's ID on a single valid/ready response channel. It sits between several client blocks and the arithmetic datapath, so the adder has exactly one controller.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default 2: requester ID width; must equal clog2(`NUM_REQ`).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  bit i: requester i holds an operand pair.
- `req_a`  in  NUM_REQ*8  operand A, slice [8i+7:8i] belongs to requester i.
- `req_b`  in  NUM_REQ*8  operand B, same slicing.
- `req_ready`  out  NUM_REQ  one-hot or zero; bit i high means requester i is accepted this cycle.
- `rsp_valid`  out  1  response available.
- `rsp_id`  out  ID_W  index of the requester the response belongs to.
- `rsp_data`  out  8  sum.
- `rsp_ready`  in  1  consumer accepts the response.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if any `req_valid` is high, pick grant g. Drive `req_ready[g]`=1 combinationally (all other bits 0). At the edge, latch `op_a`, `op_b` and g; go to EXEC. If no `req_valid` is high, stay in IDLE with `req_ready`=0.
  - EXEC: the sum register loads (`op_a`+`op_b`) mod 256; the carry is discarded. Go to RESP.
  - RESP: `rsp_valid`=1, `rsp_data`=sum, `rsp_id`=g. Hold until `rsp_ready`=1, then go to IDLE.
- `req_ready` is 0 in EXEC and RESP. No new request is accepted until the response handshake completes.
- Arbitration is re-evaluated every IDLE cycle. A requester that drops `req_valid` before it is granted simply loses its turn; this is not an error.
- `rsp_*` stays stable while `rsp_valid`=1 and `rsp_ready`=0. Backpressure is unbounded.
- Grant selection depends on the configuration macro (see Configuration).

## Timing
- Request accepted at edge T.
- EXEC runs in cycle T+1.
- `rsp_valid` rises in cycle T+2 (2-cycle latency).
- Peak throughput is one operation per 3 cycles, reached when `rsp_ready` is tied high.
- If `rsp_ready` is high in the first RESP cycle, the block is in IDLE in cycle T+3 and can accept the next request at the end of that cycle.
- Reset values: state=IDLE, `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `busy`=0, rotation pointer=0, operand and sum registers=0.
- Reset asserted mid-operation (in EXEC or RESP): all outputs go to their reset values immediately, without waiting for a clock edge. The in-flight operation is dropped and no response is ever issued for it.
- First cycle after reset deasserts: the block is in IDLE and arbitrates normally.

## Configuration
- Macro `ADDER_ARB_RR_EN`.
- Defined: round-robin arbitration.
  - The search starts at pointer `ptr` and wraps from `NUM_REQ`-1 to 0.
  - On acceptance, `ptr` ← (g+1) mod `NUM_REQ`, so after granting requester `NUM_REQ`-1 the pointer returns to 0.
- Undefined: fixed priority, lowest index wins. No pointer register exists.

## Structure
- Package `adder_arb_pkg`: FSM state enum (IDLE/EXEC/RESP), `DATA_W`=8, and the default `NUM_REQ`.
- One sub-module, `rr_pick`: a combinational picker.
  - Inputs: request vector and start pointer. Outputs: one-hot grant and grant index.
  - Instantiated only when `ADDER_ARB_RR_EN` is defined; otherwise a plain priority encoder is used.
- FSM, operand/sum registers and response logic stay in `adder_arbiter`.

## Test plan
1. Single request: `req_valid`=0001, a=4, b=7, `rsp_ready`=1 → `req_ready`=0001 for one cycle. Two cycles later, `rsp_valid`=1, `rsp_id`=0, `rsp_data`=11.
2. Overflow: requester 2 sends a=200, b=100 → `rsp_data`=44 (300 mod 256), `rsp_id`=2.
3. Contention with `ADDER_ARB_RR_EN`: all four requesters held valid from reset, `rsp_ready`=1 → grant order 0,1,2,3,0. Without the macro: 0,0,0,… for as long as requester 0 stays valid.
4. Backpressure: `rsp_ready`=0 for 5 cycles during RESP → `rsp_valid`/`rsp_id`/`rsp_data` stay stable, `req_ready` stays 0 and `busy`=1. Response completes on the cycle `rsp_ready` rises.
5. Reset mid-operation: assert `reset` while in EXEC with a=8, b=12 → outputs clear immediately. After release, no response with value 20 ever appears, and the next request is served normally.
6. Idle with no requests: `req_valid`=0 for 10 cycles → `req_ready`=0, `rsp_valid`=0, `busy`=0 throughout.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the shared-adder arbiter.
// Holds the FSM state encoding, the datapath width and the default requester count.
package adder_arb_pkg;
   localparam int DATA_W      = 8;
   localparam int NUM_REQ_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;
endpackage

// File: rtl/adder_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr_i, wrapping at N-1.
// Purely combinational (0 cycles); no flow control of its own.
module rr_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic [N-1:0] gnt_o,
   output logic [W-1:0] idx_o
);
   always_comb begin
      logic          found;
      int            c;
      logic [W-1:0]  ci;
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      c     = 0;
      ci    = '0;
      for (int i = 0; i < N; i++) begin
         c = int'(ptr_i) + i;
         if (c >= N) c = c - N;
         ci = W'(c);
         if (!found && req_i[ci]) begin
            found     = 1'b1;
            gnt_o[ci] = 1'b1;
            idx_o     = ci;
         end
      end
   end
endmodule

// File: rtl/adder_arbiter.sv
// Shares one registered 8-bit adder among NUM_REQ requesters; response 2 cycles after accept,
// one op in flight, unbounded rsp backpressure holds RESP. ADDER_ARB_RR_EN selects round-robin.
module adder_arbiter
   import adder_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int ID_W    = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      rsp_valid,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_data,
   input  logic                      rsp_ready,
   output logic                      busy
);
   state_t              state_q;
   logic [DATA_W-1:0]   op_a_q, op_b_q, sum_q;
   logic [ID_W-1:0]     gid_q;
   logic                rsp_valid_q, busy_q;

   logic [NUM_REQ-1:0]  gnt;
   logic [ID_W-1:0]     gidx;
   logic [DATA_W-1:0]   op_a_d, op_b_d;

`ifdef ADDER_ARB_RR_EN
   logic [ID_W-1:0]     ptr_q;

   rr_pick #(.N(NUM_REQ), .W(ID_W)) u_pick (
      .req_i (req_valid),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (gidx)
   );
`else
   // Scan from the top so the lowest asserted index is the last (winning) write.
   always_comb begin
      gnt  = '0;
      gidx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            gnt    = '0;
            gnt[i] = 1'b1;
            gidx   = ID_W'(i);
         end
      end
   end
`endif

   assign op_a_d = req_a[int'(gidx)*DATA_W +: DATA_W];
   assign op_b_d = req_b[int'(gidx)*DATA_W +: DATA_W];

   // Gated by reset so req_ready is low while reset is held, not only after an edge.
   assign req_ready = (state_q == IDLE && !reset) ? gnt : '0;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = gid_q;
   assign rsp_data  = sum_q;
   assign busy      = busy_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         op_a_q      <= '0;
         op_b_q      <= '0;
         sum_q       <= '0;
         gid_q       <= '0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef ADDER_ARB_RR_EN
         ptr_q       <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (|req_valid) begin
                  op_a_q  <= op_a_d;
                  op_b_q  <= op_b_d;
                  gid_q   <= gidx;
                  busy_q  <= 1'b1;
                  state_q <= EXEC;
`ifdef ADDER_ARB_RR_EN
                  ptr_q   <= (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
`endif
               end
            end
            EXEC: begin
               sum_q       <= op_a_q + op_b_q;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               rsp_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: vector table plus backpressure, reset, contention and idle sequences.
module tb_adder_arbiter;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req_valid;
   logic [N*8-1:0] req_a, req_b;
   logic [N-1:0]   req_ready;
   logic           rsp_valid;
   logic [1:0]     rsp_id;
   logic [7:0]     rsp_data;
   logic           rsp_ready;
   logic           busy;

   int total = 0;
   int bad   = 0;

   adder_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_ready (rsp_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] vld;
      logic [7:0] a;
      logic [7:0] b;
      logic [1:0] id;
      logic [7:0] sum;
   } vec_t;

   vec_t vt[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [3:0] vld, input logic [7:0] a, input logic [7:0] b, input int id);
      req_a = {N{8'h5A}};
      req_b = {N{8'h5A}};
      req_a[id*8 +: 8] = a;
      req_b[id*8 +: 8] = b;
      req_valid = vld;
   endtask

   task automatic wait_grant(output logic ok);
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (req_ready != '0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL grant_timeout: got no req_ready want a grant within 20 cycles");
      end
   endtask

   task automatic run_vec(input vec_t v);
      logic ok;
      @(negedge clk);
      drive(v.vld, v.a, v.b, int'(v.id));
      rsp_ready = 1'b1;
      #1;
      wait_grant(ok);
      chk("grant", 32'(req_ready), 32'(4'b0001 << v.id));
      @(negedge clk);
      req_valid = '0;
      chk("exec_rsp_valid", 32'(rsp_valid), 0);
      chk("exec_busy", 32'(busy), 1);
      chk("exec_req_ready", 32'(req_ready), 0);
      @(negedge clk);
      chk("resp_valid", 32'(rsp_valid), 1);
      chk("resp_id", 32'(rsp_id), 32'(v.id));
      chk("resp_data", 32'(rsp_data), 32'(v.sum));
      @(negedge clk);
      chk("after_valid", 32'(rsp_valid), 0);
      chk("after_busy", 32'(busy), 0);
   endtask

   initial begin
      logic       ok;
      logic       ghost;
      logic [1:0] exp_g[5];
      int         g;

      vt[0] = '{vld: 4'b0001, a: 8'd4,   b: 8'd7,   id: 2'd0, sum: 8'd11};
      vt[1] = '{vld: 4'b0100, a: 8'd200, b: 8'd100, id: 2'd2, sum: 8'd44};
      vt[2] = '{vld: 4'b0010, a: 8'd255, b: 8'd1,   id: 2'd1, sum: 8'd0};
      vt[3] = '{vld: 4'b1000, a: 8'd128, b: 8'd127, id: 2'd3, sum: 8'd255};
      vt[4] = '{vld: 4'b0001, a: 8'd0,   b: 8'd0,   id: 2'd0, sum: 8'd0};
      vt[5] = '{vld: 4'b1000, a: 8'd17,  b: 8'd34,  id: 2'd3, sum: 8'd51};

      // reset state, with requests pending so req_ready gating is exercised
      reset     = 1'b1;
      rsp_ready = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      @(negedge clk);
      drive(4'b1111, 8'd1, 8'd1, 0);
      #1;
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      chk("rst_rsp_data", 32'(rsp_data), 0);
      req_valid = '0;
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 6; i++) run_vec(vt[i]);

      // backpressure: response held for 5 extra cycles with another request pending
      @(negedge clk);
      drive(4'b0100, 8'd10, 8'd20, 2);
      rsp_ready = 1'b0;
      #1;
      wait_grant(ok);
      chk("bp_grant", 32'(req_ready), 32'(4'b0100));
      @(negedge clk);
      req_valid = 4'b0001;
      @(negedge clk);
      chk("bp_first_valid", 32'(rsp_valid), 1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_hold_valid", 32'(rsp_valid), 1);
         chk("bp_hold_id", 32'(rsp_id), 2);
         chk("bp_hold_data", 32'(rsp_data), 30);
         chk("bp_hold_req_ready", 32'(req_ready), 0);
         chk("bp_hold_busy", 32'(busy), 1);
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      #1;
      chk("bp_release_valid", 32'(rsp_valid), 1);
      @(negedge clk);
      chk("bp_done_valid", 32'(rsp_valid), 0);
      chk("bp_done_busy", 32'(busy), 0);

      // reset while in EXEC drops the 8+12 operation
      @(negedge clk);
      drive(4'b0001, 8'd8, 8'd12, 0);
      #1;
      wait_grant(ok);
      chk("mid_grant", 32'(req_ready), 32'(4'b0001));
      @(negedge clk);
      chk("mid_exec_busy", 32'(busy), 1);
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(rsp_valid), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_data", 32'(rsp_data), 0);
      chk("mid_rst_id", 32'(rsp_id), 0);
      chk("mid_rst_req_ready", 32'(req_ready), 0);
      req_valid = '0;
      @(negedge clk);
      reset = 1'b0;
      ghost = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid) ghost = 1'b1;
      end
      chk("mid_no_ghost_rsp", 32'(ghost), 0);
      run_vec('{vld: 4'b0010, a: 8'd1, b: 8'd2, id: 2'd1, sum: 8'd3});

      // contention: all four valid from reset
`ifdef ADDER_ARB_RR_EN
      exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
      exp_g = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
      @(negedge clk);
      reset = 1'b1;
      rsp_ready = 1'b1;
      req_valid = 4'b1111;
      for (int i = 0; i < N; i++) begin
         req_a[i*8 +: 8] = 8'(i * 10);
         req_b[i*8 +: 8] = 8'd1;
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      for (int k = 0; k < 5; k++) begin
         wait_grant(ok);
         chk("cont_grant", 32'(req_ready), 32'(4'b0001 << exp_g[k]));
         g = int'(exp_g[k]);
         @(negedge clk);
         @(negedge clk);
         chk("cont_rsp_id", 32'(rsp_id), 32'(g));
         chk("cont_rsp_data", 32'(rsp_data), 32'(g * 10 + 1));
         if (k == 4) req_valid = '0;
         @(negedge clk);
      end

      // idle with no requests
      req_valid = '0;
      repeat (10) begin
         @(negedge clk);
         chk("idle_outputs", {req_ready, rsp_valid, busy}, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
